// File: rtl/param_vending_machine.sv
// rtl/param_vending_machine.sv - multi-product vending controller with credit, refund and change payout
// Optional build macro VEND_TIMEOUT_EN: auto-refund after TIMEOUT_CYCLES idle cycles in COLLECT.
module param_vending_machine #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int COIN_VAL1 = 5,
    parameter int COIN_VAL2 = 10,
    parameter int COIN_VAL3 = 25,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int SEL_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    output logic                out_valid,
    output logic [SEL_W-1:0]    out_item,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam logic [CREDIT_W:0] MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0] V1 = COIN_VAL1[CREDIT_W:0];
    localparam logic [CREDIT_W:0] V2 = COIN_VAL2[CREDIT_W:0];
    localparam logic [CREDIT_W:0] V3 = COIN_VAL3[CREDIT_W:0];

    state_t              state;
    logic [CREDIT_W:0]   coin_value;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] added_credit;
    logic [CREDIT_W-1:0] price;
    logic                sel_known;
    logic                sel_ok;
    logic [CREDIT_W-1:0] vend_credit;
    logic [1:0]          pay_code;
    logic [CREDIT_W:0]   pay_value;
    logic [CREDIT_W-1:0] remaining;
    logic                timeout_hit;

    always_comb begin
        coin_value = '0;
        case (coin)
            2'b01:   coin_value = V1;
            2'b10:   coin_value = V2;
            2'b11:   coin_value = V3;
            default: coin_value = '0;
        endcase
        credit_sum   = {1'b0, credit} + coin_value;
        coin_ok      = (coin != 2'b00) && (credit_sum <= MAX_CREDIT);
        added_credit = coin_ok ? credit_sum[CREDIT_W-1:0] : credit;

        price     = '0;
        sel_known = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel == SEL_W'(i)) begin
                price     = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_known = 1'b1;
            end
        end
        sel_ok      = sel_known && (credit >= price);
        vend_credit = added_credit - price;

        // Greedy payout; a residue smaller than the smallest coin is forfeited.
        pay_code  = 2'b00;
        pay_value = '0;
        if ({1'b0, credit} >= V3) begin
            pay_code  = 2'b11;
            pay_value = V3;
        end else if ({1'b0, credit} >= V2) begin
            pay_code  = 2'b10;
            pay_value = V2;
        end else if ({1'b0, credit} >= V1) begin
            pay_code  = 2'b01;
            pay_value = V1;
        end
        remaining = (pay_code == 2'b00) ? '0 : CREDIT_W'({1'b0, credit} - pay_value);
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;
    logic          activity;

    assign activity    = (coin != 2'b00) || sel_valid || cancel;
    assign timeout_hit = (state == COLLECT) && !activity && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if ((state != COLLECT) || activity || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            out_item     <= '0;
            change_valid <= 1'b0;
            change_coin  <= 2'b00;
            coin_reject  <= 1'b0;
            sel_reject   <= 1'b0;
            credit       <= '0;
            busy         <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= 2'b00;
            coin_reject  <= 1'b0;
            sel_reject   <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    busy <= 1'b0;
                    if ((cancel && credit != '0) || timeout_hit) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        coin_reject <= (coin != 2'b00);
                    end else if (sel_valid) begin
                        coin_reject <= (coin != 2'b00) && !coin_ok;
                        if (sel_ok) begin
                            credit    <= vend_credit;
                            out_valid <= 1'b1;
                            out_item  <= sel;
                            state     <= VEND;
                            busy      <= 1'b1;
                        end else begin
                            sel_reject <= 1'b1;
                            credit     <= added_credit;
                            state      <= (added_credit != '0) ? COLLECT : IDLE;
                        end
                    end else begin
                        coin_reject <= (coin != 2'b00) && !coin_ok;
                        credit      <= added_credit;
                        state       <= (added_credit != '0) ? COLLECT : IDLE;
                    end
                end
                // The vend cycle already pays the first change coin so it follows the dispense directly.
                VEND, CHANGE: begin
                    coin_reject  <= (coin != 2'b00);
                    change_valid <= (pay_code != 2'b00);
                    change_coin  <= pay_code;
                    credit       <= remaining;
                    state        <= (remaining != '0) ? CHANGE : IDLE;
                    busy         <= (remaining != '0);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_vending_machine.sv
// tb/tb_param_vending_machine.sv - randomized and directed check of param_vending_machine against a queue-based model
module tb_param_vending_machine;

    localparam int T_OUT = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       cancel = 1'b0;
    logic       out_valid;
    logic [1:0] out_item;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic       sel_reject;
    logic [7:0] credit;
    logic       busy;

    param_vending_machine #(.TIMEOUT_CYCLES(T_OUT)) dut (
        .clk(clk), .reset(reset), .coin(coin), .sel_valid(sel_valid), .sel(sel),
        .cancel(cancel), .out_valid(out_valid), .out_item(out_item),
        .change_valid(change_valid), .change_coin(change_coin),
        .coin_reject(coin_reject), .sel_reject(sel_reject), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    int cval[4] = '{0, 5, 10, 25};
    int prices[4] = '{10, 15, 20, 25};

    // Reference model: credit as an integer, refunds as a precomputed coin list.
    int m_credit = 0;
    int m_idle = 0;
    bit m_accept = 1;
    bit m_vend = 0;
    int pay_q[$];
    int e_out_valid, e_out_item, e_change_valid, e_change_coin, e_coin_reject, e_sel_reject, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        m_credit = 0; m_idle = 0; m_accept = 1; m_vend = 0; pay_q.delete();
        e_out_valid = 0; e_out_item = 0; e_change_valid = 0; e_change_coin = 0;
        e_coin_reject = 0; e_sel_reject = 0; e_busy = 0;
    endfunction

    function automatic void build_refund();
        int rem = m_credit;
        pay_q.delete();
        while (rem >= 5) begin
            if (rem >= 25) begin pay_q.push_back(3); rem -= 25; end
            else if (rem >= 10) begin pay_q.push_back(2); rem -= 10; end
            else begin pay_q.push_back(1); rem -= 5; end
        end
        if (rem > 0) pay_q.push_back(0);
    endfunction

    function automatic void model_step(int c, bit sv, int s, bit cn);
        bit fits, tout;
        int add, code;
        e_out_valid = 0; e_change_valid = 0; e_change_coin = 0; e_coin_reject = 0; e_sel_reject = 0;
        if (m_accept) begin
            fits = (c != 0) && (m_credit + cval[c] <= 255);
            add = fits ? cval[c] : 0;
            tout = 0;
            e_busy = 0;
`ifdef VEND_TIMEOUT_EN
            if (m_credit > 0 && c == 0 && !sv && !cn) begin
                if (m_idle == T_OUT - 1) begin tout = 1; m_idle = 0; end
                else m_idle++;
            end else m_idle = 0;
`endif
            if ((cn && m_credit > 0) || tout) begin
                build_refund();
                m_accept = 0;
                e_busy = 1;
                e_coin_reject = (c != 0);
            end else if (sv) begin
                e_coin_reject = (c != 0) && !fits;
                if (m_credit >= prices[s]) begin
                    m_credit = m_credit + add - prices[s];
                    e_out_valid = 1; e_out_item = s;
                    m_accept = 0; m_vend = 1; e_busy = 1;
                end else begin
                    e_sel_reject = 1;
                    m_credit += add;
                end
            end else begin
                e_coin_reject = (c != 0) && !fits;
                m_credit += add;
            end
        end else begin
            m_idle = 0;
            e_coin_reject = (c != 0);
            if (m_vend) begin
                m_vend = 0;
                if (m_credit > 0) build_refund();
            end
            if (pay_q.size() > 0) begin
                code = pay_q.pop_front();
                if (code != 0) begin
                    e_change_valid = 1; e_change_coin = code; m_credit -= cval[code];
                end else m_credit = 0;
            end
            if (pay_q.size() == 0) begin m_accept = 1; e_busy = 0; end
            else e_busy = 1;
        end
    endfunction

    task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s, input logic cn);
        coin = c; sel_valid = sv; sel = s; cancel = cn;
        @(posedge clk);
        model_step(int'(c), sv, int'(s), cn);
        #1;
        chk("out_valid", out_valid, e_out_valid);
        chk("out_item", out_item, e_out_item);
        chk("change_valid", change_valid, e_change_valid);
        chk("change_coin", change_coin, e_change_coin);
        chk("coin_reject", coin_reject, e_coin_reject);
        chk("sel_reject", sel_reject, e_sel_reject);
        chk("credit", credit, m_credit);
        chk("busy", busy, e_busy);
    endtask

    task automatic drain(output int n11, output int ncoins, output int nout);
        int guard = 0;
        n11 = 0; ncoins = 0; nout = 0;
        while (!m_accept && guard < 40) begin
            step(2'b00, 1'b0, 2'b00, 1'b0);
            if (change_valid) ncoins++;
            if (change_valid && change_coin == 2'b11) n11++;
            if (out_valid) nout++;
            guard++;
        end
        if (!m_accept) chk("drain_bound", 1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_change_valid"}, change_valid, 0);
        chk({tag, "_coin_reject"}, coin_reject, 0);
        chk({tag, "_sel_reject"}, sel_reject, 0);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n11, ncoins, nout, saw;
        logic [1:0] rc, rs;
        logic rsv, rcn;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Purchase with change.
        step(2'b01, 0, 0, 0);
        step(2'b01, 0, 0, 0);
        step(2'b10, 0, 0, 0);
        chk("credit_20", credit, 20);
        step(2'b00, 1, 2'b01, 0);
        chk("dispense", out_valid, 1);
        chk("dispense_item", out_item, 1);
        step(2'b00, 0, 0, 0);
        chk("change_01", change_coin, 1);
        chk("credit_after_vend", credit, 0);
        step(2'b00, 0, 0, 0);
        chk("dispense_one_cycle", out_valid, 0);

        // Cancel refund.
        step(2'b11, 0, 0, 0);
        step(2'b11, 0, 0, 0);
        step(2'b00, 0, 0, 1);
        drain(n11, ncoins, nout);
        chk("refund_two_quarters", n11, 2);
        chk("refund_no_dispense", nout, 0);

        // Insufficient credit selections.
        step(2'b01, 0, 0, 0);
        step(2'b00, 1, 2'b00, 0);
        chk("sel_reject_low", sel_reject, 1);
        step(2'b11, 1, 2'b11, 0);
        chk("sel_reject_coin_added", credit, 30);
        step(2'b00, 0, 0, 1);
        drain(n11, ncoins, nout);

        // Saturation and coins during change.
        for (int i = 0; i < 10; i++) step(2'b11, 0, 0, 0);
        step(2'b01, 0, 0, 0);
        step(2'b01, 0, 0, 0);
        chk("coin_reject_full", coin_reject, 1);
        chk("credit_255", credit, 255);
        step(2'b00, 0, 0, 1);
        step(2'b01, 0, 0, 0);
        chk("reject_in_change", coin_reject, 1);
        drain(n11, ncoins, nout);
        chk("refund_255_coins", ncoins + 1, 11);

        // Idle timeout.
        step(2'b10, 0, 0, 0);
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            step(2'b00, 0, 0, 0);
            if (change_valid && change_coin == 2'b10) saw++;
        end
`ifdef VEND_TIMEOUT_EN
        chk("timeout_refund", saw, 1);
        chk("timeout_credit", credit, 0);
`else
        chk("no_timeout_refund", saw, 0);
        chk("no_timeout_credit", credit, 10);
        step(2'b00, 0, 0, 1);
        drain(n11, ncoins, nout);
`endif

        // Asynchronous reset in the middle of a payout.
        for (int i = 0; i < 4; i++) step(2'b11, 0, 0, 0);
        step(2'b00, 0, 0, 1);
        step(2'b00, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(2'b00, 0, 0, 0);
        check_all_zero("after_reset");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rc  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            rsv = ($urandom_range(0, 3) == 0);
            rs  = 2'($urandom_range(0, 3));
            rcn = ($urandom_range(0, 15) == 0);
            if (i % 97 == 50) begin
                for (int k = 0; k < T_OUT + 2; k++) step(2'b00, 0, 0, 0);
            end
            step(rc, rsv, rs, rcn);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_vending_machine.md
Name: param_vending_machine

Overview:
- Parametrised successor to the single-product 2-bit-coin vending FSM.
- Supports NUM_ITEMS products with individual prices, three coin denominations, a saturating credit register, cancel/refund, and multi-cycle change payout (one coin per cycle, largest first).
- Sits between the coin acceptor/keypad front end and the dispenser/coin-hopper drivers.

Parameters:
- NUM_ITEMS, 4, number of selectable products (>=2).
- CREDIT_W, 8, credit register width; max credit = 2**CREDIT_W-1.
- PRICES, {8'd25,8'd20,8'd15,8'd10}, packed prices; item i at [i*CREDIT_W +: CREDIT_W].
- COIN_VAL1, 5, value of coin code 2'b01.
- COIN_VAL2, 10, value of coin code 2'b10.
- COIN_VAL3, 25, value of coin code 2'b11.
- TIMEOUT_CYCLES, 1000, idle cycles before auto-cancel (VEND_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin  in  2  coin inserted this cycle; 00 none, 01/10/11 = COIN_VAL1/2/3.
- sel_valid  in  1  product selection strobe.
- sel  in  $clog2(NUM_ITEMS)  selected item index.
- cancel  in  1  refund request.
- out_valid  out  1  one-cycle dispense pulse.
- out_item  out  $clog2(NUM_ITEMS)  item dispensed; valid with out_valid.
- change_valid  out  1  one coin paid this cycle.
- change_coin  out  2  code of coin paid (01/10/11).
- coin_reject  out  1  one-cycle pulse: coin returned unaccepted.
- sel_reject  out  1  one-cycle pulse: selection refused.
- credit  out  CREDIT_W  current credit.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- All outputs registered. Reset (reset==0, async) forces state IDLE and all outputs 0. Reset mid-VEND/CHANGE abandons the operation; no further coins are paid.
- States: IDLE, COLLECT, VEND, CHANGE.
- IDLE/COLLECT coin handling:
  - coin!=00 with credit+value <= 2**CREDIT_W-1: value added next cycle.
  - Otherwise: credit unchanged, coin_reject pulses next cycle.
  - IDLE->COLLECT when credit becomes nonzero.
- Priority in IDLE/COLLECT: cancel > sel_valid > coin.
- cancel:
  - credit>0: ->CHANGE; same-cycle coin rejected.
  - credit==0: ignored.
- sel_valid:
  - Compares the registered credit (excluding any same-cycle coin) against PRICES[sel].
  - sel>=NUM_ITEMS or credit<price: sel_reject pulse; credit unchanged except same-cycle coin still added.
  - Otherwise ->VEND. New credit = credit + coin_value - price; the coin is subject to the same saturation check and is rejected on overflow.
- VEND: exactly one cycle. out_valid=1, out_item=latched sel. Next: CHANGE if credit>0, else IDLE.
- CHANGE: each cycle pick the largest of COIN_VAL3/2/1 <= credit.
  - Assert change_valid with that code; subtract its value from credit.
  - Credit reaching 0: ->IDLE.
  - 0 < credit < COIN_VAL1: remainder forfeited, credit cleared, ->IDLE without a change pulse.
- During VEND/CHANGE: coin!=00 gives a coin_reject pulse; sel_valid and cancel are ignored (no sel_reject).
- Latency: input sampled at edge N -> credit/pulse visible after edge N+1. Dispense is 1 cycle after selection; the first change coin follows on the next cycle.

Optional Feature:
- VEND_TIMEOUT_EN defined:
  - Counter clears on any coin, sel_valid or cancel, and increments each cycle in COLLECT.
  - Reaching TIMEOUT_CYCLES acts as cancel: ->CHANGE, full refund.
  - Counter clears on leaving COLLECT and on reset.
- VEND_TIMEOUT_EN undefined: no counter; credit is held in COLLECT indefinitely.

Test Plan:
- Reset: assert reset=0 mid-stream -> all outputs 0 immediately, state IDLE; release -> credit 0, busy 0.
- Coins 01,01,10 (credit 20), then sel=1 (price 15) -> out_valid one cycle with out_item=1, then change_valid with change_coin=01 for one cycle, credit 0, IDLE.
- Coins 11,11 (credit 50), then cancel -> two change cycles, change_coin=11 each, credit 50->25->0, no out_valid.
- Coin 01 (credit 5), sel=0 (price 10) -> sel_reject pulse, credit stays 5; sel=3 together with coin=11 -> sel_reject (credit 5 < 25), credit 30.
- Ten coin=11 (credit 250), then coin=01 (255 ok), then coin=01 -> coin_reject, credit 255. Coin during CHANGE -> coin_reject, credit payout unaffected.
- With VEND_TIMEOUT_EN and TIMEOUT_CYCLES=8: coin 10, then idle for 8 cycles -> change_coin=10 once, IDLE. Without the macro, same stimulus -> credit stays 10.
